// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester and FIFO write-port signal bundle for fifo_write_arbiter
interface fifo_write_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     full;
  logic                     write_en;
  logic [WIDTH-1:0]         write_data;
  logic [OW-1:0]            owner;
  logic                     busy;

  // arbiter side
  modport slave (
    input  req, req_last, req_data, full,
    output grant, write_en, write_data, owner, busy
  );

  // requesters plus FIFO side
  modport master (
    output req, req_last, req_data, full,
    input  grant, write_en, write_data, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter in front of a shared FIFO write port
module fifo_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fifo_write_arbiter_if.slave  bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [NUM_REQ-1:0] GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0] count_q, count_d;

  logic             win_found;
  logic [OW-1:0]    win_idx;
  logic [OW-1:0]    cand;
  logic             own_req;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic             accept;
  logic             burst_end;

  // Round-robin search: last_owner+1 first, last_owner itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_owner_q + OW'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the current owner's request, last flag and word.
  always_comb begin
    own_req  = bus.req[owner_q];
    own_last = bus.req_last[owner_q];
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == owner_q) begin
        own_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A word is taken when the owner presents one and the FIFO has room; the
  // burst closes on its last word, on the MAX_BURST-th word, or when the
  // owner lets go of req (abandon, nothing written).
  always_comb begin
    accept    = (state_q == ST_BURST) && own_req && !bus.full;
    burst_end = (state_q == ST_BURST) &&
                (!own_req || (accept && (own_last || count_q == CW'(MAX_BURST - 1))));
  end

  // Next-state logic. A finished burst always drops to IDLE with last_owner
  // updated, and IDLE is where the next winner is picked; that IDLE cycle is
  // the one-cycle turnaround between consecutive bursts.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    if (state_q == ST_IDLE) begin
      if (win_found) begin
        state_d = ST_BURST;
        owner_d = win_idx;
        count_d = '0;
      end
    end else if (burst_end) begin
      state_d      = ST_IDLE;
      last_owner_d = owner_q;
      count_d      = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
    end
  end

  // State registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
    end
  end

  assign bus.write_en   = accept;
  assign bus.grant      = accept ? (GRANT_LSB << owner_q) : '0;
  assign bus.write_data = (state_q == ST_BURST) ? own_data : '0;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q == ST_BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int OW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          we;
    logic [N-1:0]  grant;
    logic [W-1:0]  wd;
    logic [OW-1:0] owner;
    logic          busy;
  } exp_t;

  exp_t         expq[$];
  logic [N-1:0] hist[$];
  int checks = 0;
  int errors = 0;

  // requester side: each holds one word until it is granted
  bit           cur_valid[N];
  bit           cur_last[N];
  logic [W-1:0] cur_data[N];
  bit           auto_on[N];
  int           last_mode[N];
  int           seq[N];
  int           last_seq[N];
  bit           rand_mode;
  bit           full_v;

  // reference arbiter state
  int m_busy, m_owner, m_last, m_count;

  exp_t mon_e;
  int   mon_r, mon_s;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("write_en",   bus.write_en,   mon_e.we);
      chk("grant",      bus.grant,      mon_e.grant);
      chk("write_data", bus.write_data, mon_e.wd);
      chk("owner",      bus.owner,      mon_e.owner);
      chk("busy",       bus.busy,       mon_e.busy);
      hist.push_back(bus.grant);
      if (bus.write_en) begin
        mon_r = int'(bus.write_data[31:24]);
        mon_s = int'(bus.write_data[15:0]);
        chk("src_range", (mon_r < N), 1);
        if (mon_r < N) begin
          chk("order", (mon_s > last_seq[mon_r]), 1);
          last_seq[mon_r] = mon_s;
        end
      end
    end
  end

  // one clock cycle: present requests, predict outputs, consume granted words
  task automatic cycle();
    exp_t e;
    int   c;
    for (int i = 0; i < N; i++) begin
      if (rand_mode && cur_valid[i] && $urandom_range(0, 31) == 0) cur_valid[i] = 0;
      if (!cur_valid[i] && auto_on[i] && (!rand_mode || $urandom_range(0, 1) == 0)) begin
        seq[i]++;
        cur_valid[i] = 1;
        cur_data[i]  = {8'(i), 8'($urandom), 16'(seq[i])};
        cur_last[i]  = (last_mode[i] == 1) || (last_mode[i] == 2 && $urandom_range(0, 2) == 0);
      end
      bus.req[i]             = cur_valid[i];
      bus.req_last[i]        = cur_last[i];
      bus.req_data[i*W +: W] = cur_data[i];
    end
    if (rand_mode) full_v = ($urandom_range(0, 3) == 0);
    bus.full = full_v;

    e = '{we: 1'b0, grant: '0, wd: '0, owner: OW'(m_owner), busy: 1'b0};
    if (!reset_n) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_count = 0;
      e.owner = '0;
    end else if (m_busy == 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (cur_valid[c]) begin
          m_busy = 1; m_owner = c; m_count = 0;
          break;
        end
      end
    end else begin
      e.busy = 1'b1;
      e.wd   = cur_data[m_owner];
      if (!cur_valid[m_owner]) begin
        m_busy = 0; m_last = m_owner; m_count = 0;
      end else if (!full_v) begin
        e.we = 1'b1;
        e.grant[m_owner] = 1'b1;
        m_count++;
        if (cur_last[m_owner] || m_count == MB) begin
          m_busy = 0; m_last = m_owner; m_count = 0;
        end
      end
    end
    expq.push_back(e);

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (e.grant[i]) cur_valid[i] = 0;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // called just after a rising edge; outputs must clear without waiting for the clock
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_write_en",   bus.write_en,   0);
    chk("rst_grant",      bus.grant,      0);
    chk("rst_busy",       bus.busy,       0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_owner",      bus.owner,      0);
    for (int i = 0; i < N; i++) begin
      cur_valid[i] = 0; auto_on[i] = 0; last_mode[i] = 0;
    end
    rand_mode = 0;
    full_v    = 0;
    run(2);
    reset_n = 1'b1;
  endtask

  task automatic chk_hist(string name, logic [N-1:0] want[$]);
    chk({name, "_len"}, hist.size(), want.size());
    for (int k = 0; k < want.size() && k < hist.size(); k++)
      chk($sformatf("%s[%0d]", name, k + 1), hist[k], want[k]);
  endtask

  initial begin
    logic [N-1:0] want[$];
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; last_seq[i] = -1; cur_data[i] = '0;
    end
    bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.full = 1'b0;
    m_busy = 0; m_owner = 0; m_last = N - 1; m_count = 0;
    @(posedge clk);
    #1;

    // all requesters, single-word bursts: 0,1,2,3,0 on even cycles
    do_reset();
    for (int i = 0; i < N; i++) begin auto_on[i] = 1; last_mode[i] = 1; end
    hist.delete();
    run(10);
    want = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    chk_hist("rr_grant", want);

    // lone requester 2, no last: bursts capped at MAX_BURST with one idle gap
    do_reset();
    auto_on[2] = 1;
    hist.delete();
    run(10);
    want = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
    chk_hist("max_burst", want);

    // owner 1 stalled by full for three cycles, burst still completes at 4 words
    do_reset();
    auto_on[1] = 1;
    hist.delete();
    run(2);
    full_v = 1;
    run(3);
    full_v = 0;
    run(4);
    want = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    chk_hist("full_stall", want);

    // owner 3 drops req after two words; 0 wins next even though 3 comes back
    do_reset();
    auto_on[3] = 1;
    hist.delete();
    run(3);
    auto_on[3] = 0; cur_valid[3] = 0; auto_on[0] = 1;
    run(1);
    auto_on[3] = 1;
    run(2);
    want = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1};
    chk_hist("abandon", want);

    // reset in the middle of a burst by owner 2, then all requesters
    do_reset();
    auto_on[2] = 1;
    run(3);
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_write_en", bus.write_en, 1);
    do_reset();
    for (int i = 0; i < N; i++) begin auto_on[i] = 1; last_mode[i] = 1; end
    hist.delete();
    run(2);
    want = '{4'h0, 4'h1};
    chk_hist("post_rst", want);

    // randomized requests, last flags, drops and full
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < N; i++) begin auto_on[i] = 1; last_mode[i] = 2; end
    run(3000);

    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
